// File: rtl/lcd_char_driver.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_char_driver
//  Description : HD44780 8-bit character LCD driver. Powers up, initialises
//                the panel, then writes two 16-character lines per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_char_driver #(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_CMD   = 2500,
    parameter int unsigned T_CLR   = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_valid,
    input  logic [31:0] lcd_data_str_0_0,
    input  logic [31:0] lcd_data_str_0_1,
    input  logic [31:0] lcd_data_str_0_2,
    input  logic [31:0] lcd_data_str_0_3,
    input  logic [31:0] lcd_data_str_1_0,
    input  logic [31:0] lcd_data_str_1_1,
    input  logic [31:0] lcd_data_str_1_2,
    input  logic [31:0] lcd_data_str_1_3,
    output logic        lcd_ready,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_db
);

    // A zero-length phase still occupies one cycle.
    localparam logic [31:0] c_PWRUP_CYC = (T_PWRUP == 0) ? 32'd1 : 32'(T_PWRUP);
    localparam logic [31:0] c_SETUP_CYC = (T_SETUP == 0) ? 32'd1 : 32'(T_SETUP);
    localparam logic [31:0] c_EN_CYC    = (T_EN    == 0) ? 32'd1 : 32'(T_EN);
    localparam logic [31:0] c_CMD_CYC   = (T_CMD   == 0) ? 32'd1 : 32'(T_CMD);
    localparam logic [31:0] c_CLR_CYC   = (T_CLR   == 0) ? 32'd1 : 32'(T_CLR);

    localparam logic [2:0] c_ST_PWRUP = 3'd0;
    localparam logic [2:0] c_ST_INIT  = 3'd1;
    localparam logic [2:0] c_ST_IDLE  = 3'd2;
    localparam logic [2:0] c_ST_SETUP = 3'd3;
    localparam logic [2:0] c_ST_PULSE = 3'd4;
    localparam logic [2:0] c_ST_HOLD  = 3'd5;

    localparam logic [5:0] c_INIT_LAST  = 6'd3;
    localparam logic [5:0] c_FRAME_LAST = 6'd33;

    logic [2:0]   r_state;
    logic [31:0]  r_cnt;
    logic [5:0]   r_idx;
    logic         r_init;
    logic [255:0] r_buf;
    logic         r_ready;
    logic         r_e;
    logic         r_rs;
    logic [7:0]   r_db;

    logic [2:0]   w_state;
    logic [31:0]  w_cnt;
    logic [5:0]   w_idx;
    logic         w_init;
    logic         w_cap;
    logic         w_rs;
    logic [7:0]   w_db;
    logic         w_last;
    logic [31:0]  w_hold_cyc;
    logic [5:0]   w_launch_idx;
    logic         w_launch_init;
    logic [8:0]   w_launch_word;

    // {rs, db} for write `idx` of the init sequence or of a frame.
    function automatic logic [8:0] f_write_word(
        input logic         init_seq,
        input logic [5:0]   idx,
        input logic [255:0] frame
    );
        logic [4:0] v_byte;
        logic [8:0] v_word;
        v_byte = 5'd0;
        v_word = 9'h000;
        if (init_seq) begin
            case (idx[1:0])
                2'd0:    v_word = {1'b0, 8'h38};
                2'd1:    v_word = {1'b0, 8'h0C};
                2'd2:    v_word = {1'b0, 8'h06};
                default: v_word = {1'b0, 8'h01};
            endcase
        end else if (idx == 6'd0) begin
            v_word = {1'b0, 8'h80};
        end else if (idx == 6'd17) begin
            v_word = {1'b0, 8'hC0};
        end else begin
            if (idx < 6'd17) begin
                v_byte = 5'(idx - 6'd1);
            end else begin
                v_byte = 5'(idx - 6'd2);
            end
            v_word = {1'b1, frame[{v_byte, 3'b000} +: 8]};
        end
        return v_word;
    endfunction

    assign w_last        = (r_cnt <= 32'd1);
    assign w_hold_cyc    = (!r_rs && (r_db == 8'h01)) ? c_CLR_CYC : c_CMD_CYC;
    assign w_launch_idx  = (r_state == c_ST_HOLD) ? (r_idx + 6'd1) : 6'd0;
    assign w_launch_init = (r_state == c_ST_IDLE) ? 1'b0 : r_init;
    assign w_launch_word = f_write_word(w_launch_init, w_launch_idx, r_buf);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_init  = r_init;
        w_cap   = 1'b0;
        w_rs    = r_rs;
        w_db    = r_db;
        case (r_state)
            c_ST_PWRUP: begin
                if (w_last) begin
                    w_state = c_ST_INIT;
                    w_idx   = 6'd0;
                    w_init  = 1'b1;
                end else begin
                    w_cnt = r_cnt - 32'd1;
                end
            end
            c_ST_INIT: begin
                w_state       = c_ST_SETUP;
                w_cnt         = c_SETUP_CYC;
                w_idx         = 6'd0;
                {w_rs, w_db}  = w_launch_word;
            end
            c_ST_IDLE: begin
                if (lcd_valid && r_ready) begin
                    w_cap        = 1'b1;
                    w_init       = 1'b0;
                    w_idx        = 6'd0;
                    w_state      = c_ST_SETUP;
                    w_cnt        = c_SETUP_CYC;
                    {w_rs, w_db} = w_launch_word;
                end
            end
            c_ST_SETUP: begin
                if (w_last) begin
                    w_state = c_ST_PULSE;
                    w_cnt   = c_EN_CYC;
                end else begin
                    w_cnt = r_cnt - 32'd1;
                end
            end
            c_ST_PULSE: begin
                if (w_last) begin
                    w_state = c_ST_HOLD;
                    w_cnt   = w_hold_cyc;
                end else begin
                    w_cnt = r_cnt - 32'd1;
                end
            end
            c_ST_HOLD: begin
                if (w_last) begin
                    // HOLD chains straight into the next SETUP so no idle gap appears.
                    if (r_idx == (r_init ? c_INIT_LAST : c_FRAME_LAST)) begin
                        w_state = c_ST_IDLE;
                    end else begin
                        w_idx        = r_idx + 6'd1;
                        w_state      = c_ST_SETUP;
                        w_cnt        = c_SETUP_CYC;
                        {w_rs, w_db} = w_launch_word;
                    end
                end else begin
                    w_cnt = r_cnt - 32'd1;
                end
            end
            default: begin
                w_state = c_ST_PWRUP;
                w_cnt   = c_PWRUP_CYC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_PWRUP;
            r_cnt   <= c_PWRUP_CYC;
            r_idx   <= 6'd0;
            r_init  <= 1'b1;
            r_ready <= 1'b0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_db    <= 8'h00;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_init  <= w_init;
            r_ready <= (w_state == c_ST_IDLE);
            r_e     <= (w_state == c_ST_PULSE);
            r_rs    <= w_rs;
            r_db    <= w_db;
        end
    end

    // Frame buffer: byte n of the display is r_buf[8n +: 8], line 0 first.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_buf <= {lcd_data_str_1_3, lcd_data_str_1_2, lcd_data_str_1_1, lcd_data_str_1_0,
                      lcd_data_str_0_3, lcd_data_str_0_2, lcd_data_str_0_1, lcd_data_str_0_0};
        end
    end

    assign lcd_ready = r_ready;
    assign lcd_e     = r_e;
    assign lcd_rs    = r_rs;
    assign lcd_db    = r_db;
    assign lcd_rw    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_char_driver
//  Description : Scoreboard bench for lcd_char_driver with a write-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_char_driver;

    localparam int unsigned P_PWRUP = 20;
    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_EN    = 3;
    localparam int unsigned P_CMD   = 5;
    localparam int unsigned P_CLR   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_valid;
    logic [31:0] s0 [4];
    logic [31:0] s1 [4];
    logic        lcd_ready, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_db;

    always #5 clk = ~clk;

    lcd_char_driver #(
        .T_PWRUP(P_PWRUP), .T_SETUP(P_SETUP), .T_EN(P_EN), .T_CMD(P_CMD), .T_CLR(P_CLR)
    ) dut (
        .clk(clk), .rst(rst), .lcd_valid(lcd_valid),
        .lcd_data_str_0_0(s0[0]), .lcd_data_str_0_1(s0[1]),
        .lcd_data_str_0_2(s0[2]), .lcd_data_str_0_3(s0[3]),
        .lcd_data_str_1_0(s1[0]), .lcd_data_str_1_1(s1[1]),
        .lcd_data_str_1_2(s1[2]), .lcd_data_str_1_3(s1[3]),
        .lcd_ready(lcd_ready), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // Model of one frame: cursor command then 16 characters, per line, leftmost byte first.
    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h80});
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back({1'b1, 8'((s0[w] >> (8 * b)) & 32'hFF)});
        exp_q.push_back({1'b0, 8'hC0});
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back({1'b1, 8'((s1[w] >> (8 * b)) & 32'hFF)});
    endtask

    // Monitor: pops one expected write per E rising edge and measures phase lengths.
    logic       m_prev_e, m_have_prev, m_rdy_seen, m_hold_done, m_hold_bad;
    logic [8:0] m_cur, m_last_bus;
    int         m_hi, m_low, m_hold, m_since_rdy, m_run, m_pwr;

    always @(negedge clk) begin
        logic [8:0] bus;
        logic [8:0] exp_w;
        bus = {lcd_rs, lcd_db};
        if (rst) begin
            m_prev_e    = 1'b0;
            m_have_prev = 1'b0;
            m_rdy_seen  = 1'b0;
            m_hold_done = 1'b1;
            m_hold_bad  = 1'b0;
            m_pwr       = 0;
            m_run       = 1;
            m_low       = 0;
            m_hold      = 0;
            m_hi        = 0;
            m_since_rdy = 0;
            m_cur       = bus;
            m_last_bus  = bus;
        end else begin
            if (bus == m_last_bus) m_run++;
            else m_run = 1;
            if (lcd_e && !m_prev_e) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got rs/db 0x%0h, required no write at %0t", bus, $time);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("write_rs_db", 32'(bus), 32'(exp_w));
                end
                chk("setup_stable", 32'(m_run >= int'(P_SETUP) + 1), 32'd1);
                if (!m_have_prev) begin
                    chk("pwrup_len", 32'(m_pwr >= int'(P_PWRUP)), 32'd1);
                    chk("ready_before_init", 32'(m_rdy_seen), 32'd0);
                end else if (m_rdy_seen) begin
                    chk("setup_after_idle", 32'(m_since_rdy), 32'(P_SETUP));
                end else begin
                    chk("hold_plus_setup", 32'(m_low), 32'(m_hold + int'(P_SETUP)));
                end
                m_hi       = 1;
                m_cur      = bus;
                m_rdy_seen = 1'b0;
            end else if (lcd_e) begin
                m_hi++;
                if (bus !== m_cur) m_hold_bad = 1'b1;
            end else if (m_prev_e) begin
                chk("e_width", 32'(m_hi), 32'(P_EN));
                m_hold      = (m_cur == 9'h001) ? int'(P_CLR) : int'(P_CMD);
                m_low       = 1;
                m_have_prev = 1'b1;
                m_hold_done = 1'b0;
                if (bus !== m_cur || lcd_ready) m_hold_bad = 1'b1;
            end else begin
                m_low++;
                m_pwr++;
                if (!m_hold_done) begin
                    if (m_low <= m_hold) begin
                        if (bus !== m_cur || lcd_ready) m_hold_bad = 1'b1;
                    end else begin
                        chk("bus_stable", 32'(m_hold_bad), 32'd0);
                        chk("ready_after_hold", 32'(lcd_ready), 32'(exp_q.size() == 0));
                        m_hold_done = 1'b1;
                        m_hold_bad  = 1'b0;
                    end
                end
                if (lcd_ready) begin
                    m_rdy_seen  = 1'b1;
                    m_since_rdy = 0;
                end else begin
                    m_since_rdy++;
                end
            end
            m_prev_e   = lcd_e;
            m_last_bus = bus;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_strs();
        for (int i = 0; i < 4; i++) begin
            s0[i] = $urandom;
            s1[i] = $urandom;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(lcd_ready && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(lcd_ready && exp_q.size() == 0), 32'd1);
    endtask

    task automatic send_frame();
        lcd_valid = 1'b1;
        push_frame();
        step();
        lcd_valid = 1'b0;
        chk("ready_drop", 32'(lcd_ready), 32'd0);
    endtask

    initial begin
        int   pulses;
        int   n;
        int   frames;
        logic prev;
        rst       = 1'b1;
        lcd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s0[i] = 32'h0;
            s1[i] = 32'h0;
        end
        push_init();
        repeat (3) step();
        chk("reset_outputs", 32'({lcd_ready, lcd_e, lcd_rs, lcd_rw, lcd_db}), 32'd0);
        rst = 1'b0;
        wait_idle("init_done", 400);

        rand_strs();
        s0[0] = 32'h4C4C4548;
        send_frame();
        wait_idle("frame_hello_done", 800);

        rand_strs();
        send_frame();
        repeat (40) step();
        lcd_valid = 1'b1;
        rand_strs();
        step();
        lcd_valid = 1'b0;
        rand_strs();
        chk("valid_ignored_busy", 32'(lcd_ready), 32'd0);
        wait_idle("frame_midchange_done", 800);

        rand_strs();
        send_frame();
        pulses = 0;
        n      = 0;
        prev   = lcd_e;
        while (pulses < 10 && n < 1000) begin
            step();
            n++;
            if (lcd_e && !prev) pulses++;
            prev = lcd_e;
        end
        chk("reach_pulse10", 32'(pulses), 32'd10);
        rst = 1'b1;
        exp_q.delete();
        push_init();
        step();
        chk("e_low_after_reset", 32'(lcd_e), 32'd0);
        chk("ready_low_in_reset", 32'(lcd_ready), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        wait_idle("reinit_done", 400);
        repeat (30) step();

        rand_strs();
        lcd_valid = 1'b1;
        frames    = 0;
        n         = 0;
        while (frames < 3 && n < 2000) begin
            if (lcd_ready) begin
                push_frame();
                frames++;
                step();
                n++;
                chk("one_frame_per_idle", 32'(lcd_ready), 32'd0);
                rand_strs();
            end else begin
                step();
                n++;
            end
        end
        lcd_valid = 1'b0;
        chk("b2b_frames", 32'(frames), 32'd3);
        wait_idle("b2b_done", 1500);

        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(1, 5)) step();
            rand_strs();
            send_frame();
            wait_idle("rand_frame_done", 800);
        end
        repeat (5) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
